qm_mem_arbiter: RTL
===================

Name: qm_mem_arbiter

Overview:
- Shares the single memory-controller command/read port between two burst-read requesters: port 0 is the instruction cache and port 1 is the data-cache fill path.
- Grants one requester at a time, round-robin, and issues that requester's read command.
- Streams the returned read-FIFO words back to the granted requester and signals burst completion.
- Sits between the caches and the DDR controller, in the same clock domain as the CPU.

Parameters:
- TIMEOUT, 1023, number of consecutive DATA-state cycles without a popped word before the burst is aborted. Range 1..65535.

Ports:
- clk  in  1  system clock; also drives mem_cmd_clk and mem_rd_clk.
- reset  in  1  synchronous, active-high.
- r0_req  in  1  port 0 burst request; held until r0_done.
- r0_addr  in  30  port 0 byte address for the controller.
- r0_bl  in  6  port 0 burst length minus one.
- r0_gnt  out  1  port 0 owns the memory port.
- r0_data  out  32  read word for port 0.
- r0_valid  out  1  r0_data is valid this cycle.
- r0_done  out  1  one-cycle pulse ending the port 0 burst.
- r1_req, r1_addr, r1_bl, r1_gnt, r1_data, r1_valid, r1_done: same as port 0, for port 1.
- err  out  1  one-cycle pulse when a burst times out.
- mem_cmd_clk  out  1  equal to clk.
- mem_cmd_en  out  1  command strobe.
- mem_cmd_instr  out  3  constant 3'b001 (read) while mem_cmd_en is high; 0 otherwise.
- mem_cmd_bl  out  6  latched burst length.
- mem_cmd_addr  out  30  latched address.
- mem_cmd_full  in  1  command FIFO full.
- mem_cmd_empty  in  1  unused.
- mem_rd_clk  out  1  equal to clk.
- mem_rd_en  out  1  read-FIFO pop enable.
- mem_rd_data  in  32  read-FIFO data.
- mem_rd_empty  in  1  read-FIFO empty.
- mem_rd_full  in  1  unused.
- mem_rd_count  in  7  unused.

Behaviour:
- States: IDLE, CMD, DATA.
- Reset forces IDLE. All registered outputs go to 0: gnt, mem_cmd_en, mem_cmd_bl, mem_cmd_addr, and the word and timeout counters. Priority pointer is set to port 0.
- Reset mid-burst aborts immediately; no done pulse. Words already queued in the controller are not drained; clearing them is the system's responsibility.
- IDLE, no req: stay in IDLE.
- IDLE, exactly one req: grant that port.
- IDLE, both req: grant the port the priority pointer indicates, then set the pointer to the other port.
- On grant (registered): rN_gnt goes to 1; addr and bl are latched into mem_cmd_addr and mem_cmd_bl; word counter is cleared; state goes to CMD.
- CMD: mem_cmd_en = 1 only in a cycle where mem_cmd_full = 0 (registered strobe, exactly one cycle high). Next state is DATA. While mem_cmd_full = 1, wait with mem_cmd_en = 0.
- DATA: mem_rd_en = 1 combinationally. A pop is mem_rd_en && !mem_rd_empty.
  - Each pop: granted rN_valid = 1 and rN_data = mem_rd_data in the same cycle; word counter increments; timeout counter clears.
  - Pop with word counter == latched bl: rN_done = 1 in the same cycle; state goes to IDLE; gnt drops next cycle.
  - Example: bl = 3 gives exactly 4 valid pulses, done on the 4th.
- Ungranted port: valid = 0, done = 0. Its data output mirrors mem_rd_data and is don't-care.
- Timeout counter increments in each DATA cycle without a pop. When it reaches TIMEOUT, in that cycle:
  - err = 1 and rN_done = 1 for the granted port, with rN_valid = 0;
  - then state goes to IDLE.
- req deasserted during a burst is ignored; the burst completes normally.
- A new grant is issued no earlier than the cycle after returning to IDLE. Minimum gap between bursts is 1 idle cycle.
- Latency from req (in IDLE) to mem_cmd_en is 2 cycles when mem_cmd_full = 0.
- At most one gnt is high at any time. mem_cmd_en is never high outside CMD.

Test Plan:
- Single burst: r0 req with addr 0x0000_0100, bl = 3; FIFO supplies 0xA0..0xA3 back-to-back. Required: mem_cmd_en pulses once 2 cycles after req with addr 0x100 and bl 3; r0_valid ×4 carrying 0xA0..0xA3; r0_done on the 4th; r1 outputs stay 0.
- Simultaneous requests: r0 and r1 asserted together twice in succession. Required: first grant to r0, second to r1; never both gnts high; r1 cmd_addr equals r1_addr.
- Backpressure: mem_cmd_full held at 1 for 5 cycles after grant. Required: mem_cmd_en stays 0 until full drops, then exactly one 1-cycle pulse.
- Gapped data: mem_rd_empty toggles 1,0,1,1,0,... across a 2-word burst (bl = 1). Required: valid only on non-empty cycles; done with the 2nd word.
- Timeout: TIMEOUT = 8; mem_rd_empty stuck at 1 after the command. Required: err and r1_done pulse together after 8 DATA cycles, no valid; next request is granted normally.
- Reset mid-burst: assert reset after 2 of 4 words. Required: all outputs 0 next cycle; no done pulse; after reset, simultaneous requests grant r0 first.

Source files
------------

// File: rtl/qm_mem_arbiter.sv
// rtl/qm_mem_arbiter.sv - round-robin arbiter sharing one memory-controller read port between two burst requesters
module qm_mem_arbiter #(
    parameter int TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        r0_req,
    input  logic [29:0] r0_addr,
    input  logic [5:0]  r0_bl,
    output logic        r0_gnt,
    output logic [31:0] r0_data,
    output logic        r0_valid,
    output logic        r0_done,
    input  logic        r1_req,
    input  logic [29:0] r1_addr,
    input  logic [5:0]  r1_bl,
    output logic        r1_gnt,
    output logic [31:0] r1_data,
    output logic        r1_valid,
    output logic        r1_done,
    output logic        err,
    output logic        mem_cmd_clk,
    output logic        mem_cmd_en,
    output logic [2:0]  mem_cmd_instr,
    output logic [5:0]  mem_cmd_bl,
    output logic [29:0] mem_cmd_addr,
    input  logic        mem_cmd_full,
    input  logic        mem_cmd_empty,
    output logic        mem_rd_clk,
    output logic        mem_rd_en,
    input  logic [31:0] mem_rd_data,
    input  logic        mem_rd_empty,
    input  logic        mem_rd_full,
    input  logic [6:0]  mem_rd_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  gnt;
    logic        prio;
    logic        cmd_en;
    logic [5:0]  cmd_bl;
    logic [29:0] cmd_addr;
    logic [5:0]  word_cnt;
    logic [15:0] to_cnt;

    logic        any_req;
    logic        both_req;
    logic        pick;
    logic        pop;
    logic        last_word;
    logic        to_hit;
    logic        burst_end;
    logic        unused_inputs;

    assign unused_inputs = ^{mem_cmd_empty, mem_rd_full, mem_rd_count};

    // pick = 1 selects port 1; the pointer only matters when both ask at once
    assign any_req  = r0_req | r1_req;
    assign both_req = r0_req & r1_req;
    assign pick     = both_req ? prio : r1_req;

    assign pop       = (state == DATA) && !mem_rd_empty;
    assign last_word = pop && (word_cnt == cmd_bl);
    assign to_hit    = (state == DATA) && !pop && (to_cnt == TO_LAST);
    assign burst_end = last_word | to_hit;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = CMD;
            CMD:     if (cmd_en) state_nxt = DATA;
            DATA:    if (burst_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            gnt      <= 2'b00;
            prio     <= 1'b0;
            cmd_en   <= 1'b0;
            cmd_bl   <= 6'd0;
            cmd_addr <= 30'd0;
            word_cnt <= 6'd0;
            to_cnt   <= 16'd0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt      <= pick ? 2'b10 : 2'b01;
                        cmd_addr <= pick ? r1_addr : r0_addr;
                        cmd_bl   <= pick ? r1_bl : r0_bl;
                        word_cnt <= 6'd0;
                        to_cnt   <= 16'd0;
                        if (both_req) prio <= ~pick;
                    end
                end
                CMD: begin
                    // strobe is raised once, on the first non-full cycle, then leaves CMD
                    cmd_en <= !cmd_en && !mem_cmd_full;
                end
                DATA: begin
                    if (pop) begin
                        word_cnt <= word_cnt + 6'd1;
                        to_cnt   <= 16'd0;
                    end else begin
                        to_cnt <= to_cnt + 16'd1;
                    end
                    if (burst_end) gnt <= 2'b00;
                end
                default: gnt <= 2'b00;
            endcase
        end
    end

    assign r0_gnt   = gnt[0];
    assign r1_gnt   = gnt[1];
    assign r0_data  = mem_rd_data;
    assign r1_data  = mem_rd_data;
    assign r0_valid = pop & gnt[0];
    assign r1_valid = pop & gnt[1];
    assign r0_done  = burst_end & gnt[0];
    assign r1_done  = burst_end & gnt[1];
    assign err      = to_hit;

    assign mem_cmd_clk   = clk;
    assign mem_rd_clk    = clk;
    assign mem_cmd_en    = cmd_en;
    assign mem_cmd_instr = cmd_en ? 3'b001 : 3'b000;
    assign mem_cmd_bl    = cmd_bl;
    assign mem_cmd_addr  = cmd_addr;
    assign mem_rd_en     = (state == DATA);

endmodule
